tdc_tap_encoder: RTL and testbench

- Downstream consumer of a chain of CARRY4 primitives used as a tapped delay line (TDC).
- Captures the concatenated CO outputs as a thermometer code and double-registers them for metastability.
- Applies bubble correction, population-counts the result into a fine-time code, and presents it through a valid/ready output buffer.
- Sits between the carry-chain instance and the timestamp assembly logic.

---
 rtl/tdc_pkg.sv | 30 +++
 rtl/tdc_popcount.sv | 60 ++++++
 rtl/tdc_tap_encoder.sv | 117 +++++++++++
 tb/tb_tdc_tap_encoder.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/tdc_pkg.sv
// Shared constants, helpers and the result record for the carry-chain TDC tap encoder.
package tdc_pkg;

  localparam int TDC_TAPS   = 64;
  // Wide enough to hold the fine-time code of any practical chain length.
  localparam int RES_CODE_W = 16;

  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

  typedef struct packed {
    logic [RES_CODE_W-1:0] code;
    logic                  ovf;
    logic                  unf;
  } result_t;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/tdc_popcount.sv
// Two-half registered population count with all-ones / all-zeros flags.
module tdc_popcount
  import tdc_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] bits_i,
  input  logic             valid_i,
  output logic             valid_o,
  output result_t          result_o
);

  localparam int HALF   = WIDTH / 2;
  localparam int PART_W = clog2(HALF + 1);

  logic [PART_W-1:0] lo_d, lo_q, hi_d, hi_q;
  logic              ovf_d, ovf_q, unf_d, unf_q;
  logic              valid_d, valid_q;

  always_comb begin
    lo_d = '0;
    hi_d = '0;
    for (int i = 0; i < HALF; i++) begin
      lo_d = lo_d + PART_W'(bits_i[i]);
      hi_d = hi_d + PART_W'(bits_i[HALF + i]);
    end
    ovf_d   = &bits_i;
    unf_d   = ~|bits_i;
    valid_d = valid_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lo_q    <= '0;
      hi_q    <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
      valid_q <= valid_d;
    end
  end

  // The final add happens combinationally here and is captured by the consumer.
  always_comb begin
    result_o      = '0;
    result_o.code = RES_CODE_W'(lo_q) + RES_CODE_W'(hi_q);
    result_o.ovf  = ovf_q;
    result_o.unf  = unf_q;
  end

  assign valid_o = valid_q;

endmodule

// File: rtl/tdc_tap_encoder.sv
// Carry-chain TDC tap encoder: two-flop sync, bubble filter, popcount, single-entry output buffer.
module tdc_tap_encoder
  import tdc_pkg::*;
#(
  parameter int TAPS   = TDC_TAPS,
  parameter int CODE_W = clog2(TAPS + 1),
  parameter int DROP_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [TAPS-1:0]   taps_i,
  input  logic              hit_i,
  input  logic              en_i,
  output logic [CODE_W-1:0] code_o,
  output logic              valid_o,
  input  logic              ready_i,
  output logic              ovf_o,
  output logic              unf_o,
  output logic [DROP_W-1:0] drop_cnt_o
);

  logic [TAPS-1:0]   s0_d, s0_q, s1_d, s1_q, b_d, b_q;
  logic              h0_d, h0_q, h1_d, h1_q, h2_d, h2_q;
  logic [TAPS+1:0]   s1_ext;
  logic              pc_valid;
  result_t           pc_res;
  logic [CODE_W-1:0] code_d, code_q;
  logic              ovf_d, ovf_q, unf_d, unf_q, valid_d, valid_q;
  logic [DROP_W-1:0] drop_d, drop_q;

  // Chain edge is assumed to enter below tap 0 and never reach past the last tap.
  always_comb begin
    s0_d   = taps_i;
    h0_d   = hit_i & en_i;
    s1_d   = s0_q;
    h1_d   = h0_q;
    h2_d   = h1_q;
    s1_ext = {1'b0, s1_q, 1'b1};
    b_d    = '0;
    for (int i = 0; i < TAPS; i++) begin
      b_d[i] = maj3(s1_ext[i], s1_ext[i+1], s1_ext[i+2]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s0_q <= '0;
      s1_q <= '0;
      b_q  <= '0;
      h0_q <= 1'b0;
      h1_q <= 1'b0;
      h2_q <= 1'b0;
    end else begin
      s0_q <= s0_d;
      s1_q <= s1_d;
      b_q  <= b_d;
      h0_q <= h0_d;
      h1_q <= h1_d;
      h2_q <= h2_d;
    end
  end

  tdc_popcount #(
    .WIDTH (TAPS)
  ) u_popcount (
    .clk      (clk),
    .rst_n    (rst_n),
    .bits_i   (b_q),
    .valid_i  (h2_q),
    .valid_o  (pc_valid),
    .result_o (pc_res)
  );

  // A result arriving at a full, stalled buffer is discarded and counted.
  always_comb begin
    code_d  = code_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    valid_d = valid_q;
    drop_d  = drop_q;
    if (pc_valid) begin
      if (!valid_q || ready_i) begin
        code_d  = CODE_W'(pc_res.code);
        ovf_d   = pc_res.ovf;
        unf_d   = pc_res.unf;
        valid_d = 1'b1;
      end else if (drop_q != {DROP_W{1'b1}}) begin
        drop_d = drop_q + 1'b1;
      end
    end else if (valid_q && ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      code_q  <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
      valid_q <= 1'b0;
      drop_q  <= '0;
    end else begin
      code_q  <= code_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
      valid_q <= valid_d;
      drop_q  <= drop_d;
    end
  end

  assign code_o     = code_q;
  assign ovf_o      = ovf_q & valid_q;
  assign unf_o      = unf_q & valid_q;
  assign valid_o    = valid_q;
  assign drop_cnt_o = drop_q;

endmodule

// File: tb/tb_tdc_tap_encoder.sv
// Self-checking bench for tdc_tap_encoder: directed and random hits against a transaction-level model.
module tb_tdc_tap_encoder;

  localparam int TAPS   = 64;
  localparam int CODE_W = 7;
  localparam int DROP_W = 8;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [TAPS-1:0]   taps_i = '0;
  logic              hit_i = 1'b0;
  logic              en_i = 1'b1;
  logic              ready_i = 1'b1;
  logic [CODE_W-1:0] code_o;
  logic              valid_o;
  logic              ovf_o;
  logic              unf_o;
  logic [DROP_W-1:0] drop_cnt_o;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    int due;
    int code;
  } pend_t;

  pend_t pend[$];
  bit    mValid = 1'b0;
  int    mCode = 0;
  int    mDrop = 0;

  tdc_tap_encoder #(
    .TAPS   (TAPS),
    .CODE_W (CODE_W),
    .DROP_W (DROP_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .taps_i     (taps_i),
    .hit_i      (hit_i),
    .en_i       (en_i),
    .code_o     (code_o),
    .valid_o    (valid_o),
    .ready_i    (ready_i),
    .ovf_o      (ovf_o),
    .unf_o      (unf_o),
    .drop_cnt_o (drop_cnt_o)
  );

  always #5 clk = ~clk;

  // Tap i counts as filled when at least two of (i-1, i, i+1) are high; below 0 is high, above the top is low.
  function automatic int refCode(input logic [TAPS-1:0] t);
    int n;
    int left;
    int right;
    n = 0;
    for (int i = 0; i < TAPS; i++) begin
      left  = (i == 0) ? 1 : int'(t[i-1]);
      right = (i == TAPS - 1) ? 0 : int'(t[i+1]);
      if (left + int'(t[i]) + right >= 2) n++;
    end
    return n;
  endfunction

  task automatic checkOutput();
    checks++;
    assert (valid_o === mValid) else begin
      errors++;
      $error("[TB] FAIL valid cyc=%0d observed=%b expected=%b", cyc, valid_o, mValid);
    end
    checks++;
    assert (drop_cnt_o === DROP_W'(mDrop)) else begin
      errors++;
      $error("[TB] FAIL dropCnt cyc=%0d observed=%0d expected=%0d", cyc, drop_cnt_o, mDrop);
    end
    if (mValid) begin
      checks++;
      assert (code_o === CODE_W'(mCode)) else begin
        errors++;
        $error("[TB] FAIL code cyc=%0d observed=%0d expected=%0d", cyc, code_o, mCode);
      end
      checks++;
      assert (ovf_o === (mCode == TAPS)) else begin
        errors++;
        $error("[TB] FAIL ovf cyc=%0d observed=%b expected=%b", cyc, ovf_o, (mCode == TAPS));
      end
      checks++;
      assert (unf_o === (mCode == 0)) else begin
        errors++;
        $error("[TB] FAIL unf cyc=%0d observed=%b expected=%b", cyc, unf_o, (mCode == 0));
      end
    end
  endtask

  task automatic checkValue(input string tag, input int observed, input int expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Drives one cycle of inputs, advances the model across the edge, then checks outputs.
  task automatic applyStimulus(input logic [TAPS-1:0] t, input logic h, input logic e,
                               input logic r);
    bit arriving;
    int newCode;
    taps_i  = t;
    hit_i   = h;
    en_i    = e;
    ready_i = r;
    @(posedge clk);
    cyc++;
    arriving = 1'b0;
    newCode  = 0;
    if (pend.size() > 0 && pend[0].due == cyc) begin
      arriving = 1'b1;
      newCode  = pend[0].code;
      void'(pend.pop_front());
    end
    if (arriving) begin
      if (!mValid || r) begin
        mValid = 1'b1;
        mCode  = newCode;
      end else if (mDrop < (1 << DROP_W) - 1) begin
        mDrop++;
      end
    end else if (mValid && r) begin
      mValid = 1'b0;
    end
    if (h && e) pend.push_back('{due: cyc + 4, code: refCode(t)});
    #1;
    checkOutput();
  endtask

  task automatic pulseReset();
    rst_n = 1'b0;
    #1;
    pend.delete();
    mValid = 1'b0;
    mDrop  = 0;
    checkOutput();
    checkValue("resetCode", int'(code_o), 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic idle(input int n, input logic r);
    for (int i = 0; i < n; i++) applyStimulus('0, 1'b0, 1'b1, r);
  endtask

  initial begin
    logic [TAPS-1:0] t;
    int              pos;

    $display("[TB] starting tdc_tap_encoder bench");
    pulseReset();
    idle(2, 1'b1);

    applyStimulus(64'h0000_0000_0000_00FF, 1'b1, 1'b1, 1'b1);
    idle(4, 1'b1);
    checkValue("basicCode", int'(code_o), 8);
    idle(2, 1'b1);

    applyStimulus(64'h0000_0000_0000_00FB, 1'b1, 1'b1, 1'b1);
    idle(4, 1'b1);
    checkValue("bubbleCode", int'(code_o), 8);
    applyStimulus(64'h0000_0000_0100_000F, 1'b1, 1'b1, 1'b1);
    idle(4, 1'b1);
    checkValue("strayCode", int'(code_o), 4);
    applyStimulus('1, 1'b1, 1'b1, 1'b1);
    idle(4, 1'b1);
    checkValue("allOnesCode", int'(code_o), 64);
    checkValue("allOnesOvf", int'(ovf_o), 1);
    applyStimulus('0, 1'b1, 1'b1, 1'b1);
    idle(4, 1'b1);
    checkValue("allZerosUnf", int'(unf_o), 1);
    applyStimulus(64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1, 1'b1);
    idle(4, 1'b1);
    checkValue("code63", int'(code_o), 63);
    idle(2, 1'b1);

    applyStimulus(64'h1F, 1'b1, 1'b1, 1'b1);
    applyStimulus(64'h3F, 1'b1, 1'b1, 1'b1);
    applyStimulus(64'h7F, 1'b1, 1'b1, 1'b1);
    idle(2, 1'b1);
    checkValue("b2bFirst", int'(code_o), 5);
    idle(1, 1'b1);
    checkValue("b2bSecond", int'(code_o), 6);
    idle(1, 1'b1);
    checkValue("b2bThird", int'(code_o), 7);
    idle(2, 1'b1);

    applyStimulus(64'h3FF, 1'b1, 1'b1, 1'b0);
    applyStimulus(64'hF_FFFF, 1'b1, 1'b1, 1'b0);
    idle(5, 1'b0);
    checkValue("bpHoldCode", int'(code_o), 10);
    checkValue("bpDrop", int'(drop_cnt_o), 1);
    idle(1, 1'b1);
    idle(2, 1'b1);

    for (int i = 0; i < 300; i++) applyStimulus(64'hFFFF, 1'b1, 1'b1, 1'b0);
    idle(5, 1'b0);
    checkValue("dropSat", int'(drop_cnt_o), 255);
    idle(3, 1'b1);

    applyStimulus(64'hFF, 1'b1, 1'b0, 1'b1);
    idle(6, 1'b1);

    applyStimulus(64'hFF, 1'b1, 1'b1, 1'b1);
    idle(2, 1'b1);
    pulseReset();
    idle(6, 1'b1);
    checkValue("midResetDrop", int'(drop_cnt_o), 0);

    for (int i = 0; i < 400; i++) begin
      pos = int'($urandom_range(0, TAPS));
      t = (pos == TAPS) ? '1 : ((64'd1 << pos) - 64'd1);
      if ($urandom_range(0, 2) == 0) t = t ^ (64'd1 << $urandom_range(0, TAPS - 1));
      applyStimulus(t, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 7) != 0),
                    1'($urandom_range(0, 3) != 0));
    end
    idle(6, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
